// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX/MEM/WB hazard tracker: load-use stall, bubble and forwarding select generation
module hazard_forward_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_valid,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        flush,
    output logic [1:0]  forward_sel_a,
    output logic [1:0]  forward_sel_b,
    output logic        stall,
    output logic        bubble,
    output logic [31:0] stall_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } slot_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    slot_t       ex_q, ex_d;
    slot_t       mem_q, mem_d;
    slot_t       wb_q, wb_d;
    logic [4:0]  ex_rs1_q, ex_rs1_d;
    logic [4:0]  ex_rs2_q, ex_rs2_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        load_use;
    logic        mem_fwd_ok;
    logic        wb_fwd_ok;
    logic        wb_mem_read_unused;

    // WB only needs rd/reg_write for forwarding; its load flag is carried for completeness.
    assign wb_mem_read_unused = wb_q.mem_read;

    always_comb begin
        load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid &&
                   ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
        stall  = load_use && !flush;
        bubble = stall || flush;
    end

    // Forwarding is gated by EX.valid so an empty EX slot never selects a bypass.
    always_comb begin
        mem_fwd_ok    = ex_q.valid && mem_q.valid && mem_q.reg_write && (mem_q.rd != 5'd0);
        wb_fwd_ok     = ex_q.valid && wb_q.valid && wb_q.reg_write && (wb_q.rd != 5'd0);
        forward_sel_a = SEL_RF;
        forward_sel_b = SEL_RF;
        if (mem_fwd_ok && (mem_q.rd == ex_rs1_q)) begin
            forward_sel_a = SEL_MEM;
        end else if (wb_fwd_ok && (wb_q.rd == ex_rs1_q)) begin
            forward_sel_a = SEL_WB;
        end
        if (mem_fwd_ok && (mem_q.rd == ex_rs2_q)) begin
            forward_sel_b = SEL_MEM;
        end else if (wb_fwd_ok && (wb_q.rd == ex_rs2_q)) begin
            forward_sel_b = SEL_WB;
        end
    end

    always_comb begin
        ex_d     = '0;
        ex_rs1_d = 5'd0;
        ex_rs2_d = 5'd0;
        if (!bubble && id_valid) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_rs1_d       = id_rs1;
            ex_rs2_d       = id_rs2;
        end
        mem_d = ex_q;
        wb_d  = mem_q;
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            ex_rs1_q      <= 5'd0;
            ex_rs2_q      <= 5'd0;
            stall_count_q <= 32'd0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed scoreboard bench for hazard_forward_unit
module tb_hazard_forward_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_valid, id_reg_write, id_mem_read;
    logic        flush;
    logic [1:0]  forward_sel_a, forward_sel_b;
    logic        stall, bubble;
    logic [31:0] stall_count;

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic        bb;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    hazard_forward_unit dut (
        .clk(clk),
        .rst(rst),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_rd(id_rd),
        .id_valid(id_valid),
        .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read),
        .flush(flush),
        .forward_sel_a(forward_sel_a),
        .forward_sel_b(forward_sel_b),
        .stall(stall),
        .bubble(bubble),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one ID slot at the falling edge, queue what the outputs must show, then compare.
    task automatic step(input string tag,
                        input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic fl, input logic r,
                        input logic [1:0] efa, input logic [1:0] efb,
                        input logic es, input logic eb, input logic [31:0] ec);
        exp_t e;
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr; flush = fl; rst = r;
        exp_q.push_back('{fa: efa, fb: efb, st: es, bb: eb, cnt: ec});
        #1;
        e = exp_q.pop_front();
        total++;
        assert (forward_sel_a === e.fa) else begin
            bad++; $error("FAIL %s fwd_a observed=%b expected=%b", tag, forward_sel_a, e.fa);
        end
        total++;
        assert (forward_sel_b === e.fb) else begin
            bad++; $error("FAIL %s fwd_b observed=%b expected=%b", tag, forward_sel_b, e.fb);
        end
        total++;
        assert (stall === e.st) else begin
            bad++; $error("FAIL %s stall observed=%b expected=%b", tag, stall, e.st);
        end
        total++;
        assert (bubble === e.bb) else begin
            bad++; $error("FAIL %s bubble observed=%b expected=%b", tag, bubble, e.bb);
        end
        total++;
        assert (stall_count === e.cnt) else begin
            bad++; $error("FAIL %s count observed=%0d expected=%0d", tag, stall_count, e.cnt);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_reg_write = 1'b0; id_mem_read = 1'b0;
        repeat (2) @(posedge clk);

        // MEM forwarding: add x5; sub x6,x5,x7
        //   tag        v  rs1 rs2 rd  rw mr fl rst  fa     fb     st bb cnt
        step("reset",   1, 1,  2,  5,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("mem_s2",  1, 5,  7,  6,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("mem_fwd", 0, 0,  0,  0,  0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0);
        step("mem_s4",  0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("mem_s5",  0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

        // WB forwarding: add x5; nop; or x8,x1,x5
        step("wb_s1",   1, 1,  2,  5,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("wb_s2",   0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("wb_s3",   1, 1,  5,  8,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("wb_fwd",  0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0);

        // Double hazard: add x5; add x5; and x9,x5,x5 -> MEM wins
        step("dbl_s1",  1, 1,  2,  5,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("dbl_s2",  1, 3,  4,  5,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("dbl_s3",  1, 5,  5,  9,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("dbl_fwd", 0, 0,  0,  0,  0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0);
        step("dbl_s5",  0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("dbl_s6",  0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

        // Load-use: lw x3,0(x10); add x4,x3,x2 held for the stall cycle
        step("lu_lw",   1, 10, 0,  3,  1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("lu_stall",1, 3,  2,  4,  1, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0);
        step("lu_held", 1, 3,  2,  4,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("lu_fwd",  0, 0,  0,  0,  0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1);
        step("lu_s5",   0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);

        // x0: ALU writer then reader, load to x0 then reader
        step("x0_s1",   1, 1,  1,  0,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("x0_s2",   1, 0,  0,  7,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("x0_alu",  0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("x0_lw",   1, 1,  0,  0,  1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("x0_nostl",1, 0,  0,  7,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("x0_ld",   0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("x0_s7",   0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);

        // Flush beats the load-use hazard
        step("fl_lw",   1, 10, 0,  3,  1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("fl_hit",  1, 3,  2,  4,  1, 0, 1, 0, 2'b00, 2'b00, 0, 1, 1);
        step("fl_s3",   0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("fl_s4",   0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);

        // Invalid ID slots never forward, even with matching fields
        step("iv_s1",   0, 1,  1,  5,  1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("iv_s2",   1, 5,  5,  6,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("iv_s3",   1, 1,  1,  5,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("iv_s4",   0, 5,  5,  7,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("iv_exinv",0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);

        // Reset asserted during a load-use stall
        step("rs_lw",   1, 10, 0,  3,  1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("rs_stall",1, 3,  2,  4,  1, 0, 0, 1, 2'b00, 2'b00, 1, 1, 1);
        step("rs_after",1, 3,  2,  4,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("rs_s4",   0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Port clk, input, 1 bit: core clock.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Ports id_rs1 and id_rs2, input, 5 bits each: source registers of the instruction in ID.
REQ-005 Port id_rd, input, 5 bits: destination register of the instruction in ID.
REQ-006 Ports id_valid, id_reg_write and id_mem_read, input, 1 bit each: the ID slot holds a real instruction, writes a register, and is a load, respectively.
REQ-007 Port flush, input, 1 bit: taken branch or jump resolved in EX; squashes ID.
REQ-008 Ports forward_sel_a and forward_sel_b, output, 2 bits each: select codes for the rs1/rs2 forwarding muxes in EX.
REQ-009 Port stall, output, 1 bit: hold PC and the IF/ID register.
REQ-010 Port bubble, output, 1 bit: load a NOP into ID/EX.
REQ-011 Port stall_count, output, 32 bits: saturating count of load-use stall cycles.

Function
REQ-012 The block SHALL keep three tracking slots, EX, MEM and WB; each slot holds {valid, rd, reg_write, mem_read}, and the EX slot also holds {rs1, rs2}.
REQ-013 Each cycle without stall or flush, the slots SHALL advance as ID->EX, EX->MEM, MEM->WB, with the ID fields captured from the id_* inputs.
REQ-014 When stall or flush is 1, the EX slot SHALL load a bubble (all fields 0) while MEM<=EX and WB<=MEM still advance.
REQ-015 Load-use hazard = EX.valid & EX.mem_read & EX.rd!=0 & id_valid & (EX.rd==id_rs1 | EX.rd==id_rs2).
REQ-016 stall SHALL be combinational and equal to load-use hazard & !flush; flush has priority over the hazard.
REQ-017 bubble SHALL be combinational and equal to stall | flush.
REQ-018 Each load-use hazard SHALL cause exactly one stall cycle; on the next cycle the load is in MEM, the hazard term is 0, and ID proceeds.
REQ-019 forward_sel_a SHALL be combinational, computed from the registered slot state as follows:
- 2'b01 (MEM) if MEM.valid & MEM.reg_write & MEM.rd!=0 & MEM.rd==EX.rs1;
- else 2'b10 (WB) if WB.valid & WB.reg_write & WB.rd!=0 & WB.rd==EX.rs1;
- else 2'b00 (register file).
REQ-020 forward_sel_b SHALL use the same rules as REQ-019 with EX.rs2 in place of EX.rs1.
REQ-021 When MEM and WB both match, MEM (the younger result) SHALL win.
REQ-022 Register x0 SHALL never be forwarded and SHALL never cause a stall.
REQ-023 The code 2'b11 SHALL never be driven.
REQ-024 forward_sel_a and forward_sel_b SHALL be 2'b00 whenever EX.valid=0.
REQ-025 stall_count SHALL increment by 1 on every edge where stall=1 and SHALL hold at 32'hFFFF_FFFF.
REQ-026 Inputs with id_valid=0 SHALL enter EX as an invalid slot and SHALL produce no forwarding.

Reset
REQ-027 On an edge with rst=1, all slots SHALL clear to invalid with all fields 0, and stall_count SHALL clear to 0.
REQ-028 Following reset, forward_sel_a, forward_sel_b, stall and bubble SHALL all be 0.
REQ-029 rst SHALL take priority over stall and flush.
REQ-030 Reset asserted mid-stall SHALL discard the pending hazard; the cycle after reset deasserts has stall=0.

Verification
REQ-031 MEM forwarding: issue add x5 then sub x6,x5,x7 back-to-back -> while sub is in EX, forward_sel_a=01 and forward_sel_b=00.
REQ-032 WB forwarding: issue add x5, nop, then or x8,x1,x5 -> while or is in EX, forward_sel_b=10.
REQ-033 Double hazard: issue add x5, add x5, then and x9,x5,x5 -> while and is in EX, both selects=01 (MEM priority).
REQ-034 Load-use: issue lw x3 then add x4,x3,x2 -> stall=1 and bubble=1 for exactly 1 cycle, stall_count 0->1, then forward_sel_a=10 while add is in EX.
REQ-035 x0 and flush:
- a writer to x0 followed by a reader of x0 -> selects 00 and stall 0;
- lw x3 in EX with id_rs1=3 and flush=1 -> stall=0, bubble=1, stall_count unchanged.
REQ-036 Reset mid-stall: assert rst during a load-use stall -> the next cycle has all outputs 0 and stall_count=0.
